xgmii_rx_measure: RTL and testbench

XGMII_RX_MEASURE -- requirements
Module: xgmii_rx_measure

---
 rtl/xgmii_pkg.sv | 41 ++++
 rtl/xgmii_term_find.sv | 25 ++
 rtl/xgmii_rx_measure.sv | 176 +++++++++++++++++
 tb/tb_xgmii_rx_measure.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// Shared XGMII control characters, receive FSM encoding and frame-length helpers
// used by the receive measurement block.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam int NUM_LANES = 8;
  // Running byte count width; wide enough that saturation only matters past 0xFFFF.
  localparam int CNT_W     = 17;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [15:0] len;
  } frame_rpt_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [3:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, cnt} + {{(CNT_W-3){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // The count includes the 7 preamble/SFD bytes after Start; strip them and clamp.
  function automatic logic [15:0] sat_len(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] d;
    if (cnt < CNT_W'(7)) return 16'h0000;
    d = cnt - CNT_W'(7);
    if (d > CNT_W'(16'hFFFF)) return 16'hFFFF;
    return d[15:0];
  endfunction

endpackage

// File: rtl/xgmii_term_find.sv
// Locates the lowest-numbered lane carrying a Terminate control character.
module xgmii_term_find
  import xgmii_pkg::*;
(
  input  logic [63:0] rxd_i,
  input  logic [7:0]  rxc_i,
  output logic        found_o,
  output logic [2:0]  lane_o
);

  logic [NUM_LANES-1:0] hit;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign hit[k] = rxc_i[k] && (rxd_i[8*k +: 8] == XGMII_TERM);
  end

  always_comb begin
    found_o = |hit;
    lane_o  = 3'd0;
    for (int k = NUM_LANES-1; k >= 0; k--) begin
      if (hit[k]) lane_o = 3'(k);
    end
  end

endmodule

// File: rtl/xgmii_rx_measure.sv
// XGMII receive frame delimiter and statistics: per-frame length/error report,
// cumulative counters and per-window frame/byte rates.
module xgmii_rx_measure
  import xgmii_pkg::*;
#(
  parameter int CLK_PER_SEC = 156250000,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic        frame_valid,
  output logic [15:0] frame_len,
  output logic        frame_err,
  output logic [31:0] rx_frames,
  output logic [47:0] rx_bytes,
  output logic [31:0] rx_errors,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput
);

  localparam int             WIN_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_PER_SEC - 1);

  // ---------------------------------------------------------------- decode
  logic                 term_found;
  logic [2:0]           term_lane;
  logic [NUM_LANES-1:0] err_hit;
  logic [7:0]           below_m;
  logic                 start0, start4, abort;
  logic [CNT_W-1:0]     start_cnt;

  xgmii_term_find u_term (
    .rxd_i   (xgmii_rxd),
    .rxc_i   (xgmii_rxc),
    .found_o (term_found),
    .lane_o  (term_lane)
  );

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_err
    assign err_hit[k] = xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == XGMII_ERROR);
  end

  assign start0    = xgmii_rxc[0] && (xgmii_rxd[7:0]   == XGMII_START);
  assign start4    = xgmii_rxc[4] && (xgmii_rxd[39:32] == XGMII_START);
  assign start_cnt = start0 ? CNT_W'(7) : CNT_W'(3);
  assign below_m   = (8'h01 << term_lane) - 8'h01;
  // A lane-4 Start only preempts the open frame if no Terminate precedes it.
  assign abort     = start0 || (start4 && !(term_found && (term_lane < 3'd4)));

  // ---------------------------------------------------------------- frame FSM
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ferr_q, ferr_d;
  frame_rpt_t       rpt_q, rpt_d;
  logic             close, close_err;
  logic [CNT_W-1:0] close_cnt;
  logic [15:0]      close_len;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ferr_d    = ferr_q;
    close     = 1'b0;
    close_cnt = cnt_q;
    close_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start0 && term_found && (term_lane != 3'd0)) begin
          close     = 1'b1;
          close_cnt = {{(CNT_W-3){1'b0}}, term_lane} - CNT_W'(1);
          close_err = |(xgmii_rxc & below_m & 8'hFE);
        end else if (start0 || start4) begin
          state_d = ST_FRAME;
          cnt_d   = start_cnt;
          ferr_d  = 1'b0;
        end
      end
      ST_FRAME: begin
        if (abort) begin
          close     = 1'b1;
          close_err = 1'b1;
          cnt_d     = start_cnt;
          ferr_d    = 1'b0;
        end else if (term_found) begin
          close     = 1'b1;
          close_cnt = sat_add(cnt_q, {1'b0, term_lane});
          close_err = ferr_q || (|err_hit) || (|(xgmii_rxc & below_m));
          state_d   = ST_IDLE;
        end else if (xgmii_rxc == 8'h00) begin
          cnt_d = sat_add(cnt_q, 4'd8);
        end else begin
          ferr_d = 1'b1;
        end
      end
    endcase

    close_len = sat_len(close_cnt);
    rpt_d.vld = close;
    rpt_d.len = close ? close_len : rpt_q.len;
    rpt_d.err = close ? (close_err || (close_len < 16'(MIN_LEN)) || (close_len > 16'(MAX_LEN)))
                      : rpt_q.err;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
      rpt_q   <= rpt_d;
    end
  end

  assign frame_valid = rpt_q.vld;
  assign frame_len   = rpt_q.len;
  assign frame_err   = rpt_q.err;

  // ---------------------------------------------------------------- statistics
  logic             good;
  logic [31:0]      frames_q, errors_q, pps_q, thr_q;
  logic [47:0]      bytes_q;
  logic [31:0]      acc_frames_q, acc_frames_d, acc_bytes_q, acc_bytes_d;
  logic [WIN_W-1:0] win_q;

  assign good         = rpt_q.vld && !rpt_q.err;
  // The window accumulators already include a frame reported on the terminal cycle.
  assign acc_frames_d = acc_frames_q + {31'b0, good};
  assign acc_bytes_d  = acc_bytes_q + (good ? {16'b0, rpt_q.len} : 32'b0);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      frames_q     <= '0;
      bytes_q      <= '0;
      errors_q     <= '0;
      acc_frames_q <= '0;
      acc_bytes_q  <= '0;
      pps_q        <= '0;
      thr_q        <= '0;
      win_q        <= '0;
    end else begin
      if (rpt_q.vld) begin
        if (rpt_q.err) begin
          errors_q <= errors_q + 32'd1;
        end else begin
          frames_q <= frames_q + 32'd1;
          bytes_q  <= bytes_q + {32'b0, rpt_q.len};
        end
      end
      if (win_q == WIN_LAST) begin
        win_q        <= '0;
        pps_q        <= acc_frames_d;
        thr_q        <= acc_bytes_d;
        acc_frames_q <= '0;
        acc_bytes_q  <= '0;
      end else begin
        win_q        <= win_q + WIN_W'(1);
        acc_frames_q <= acc_frames_d;
        acc_bytes_q  <= acc_bytes_d;
      end
    end
  end

  assign rx_frames     = frames_q;
  assign rx_bytes      = bytes_q;
  assign rx_errors     = errors_q;
  assign rx_pps        = pps_q;
  assign rx_throughput = thr_q;

endmodule

// File: tb/tb_xgmii_rx_measure.sv
// Scoreboard bench: frames are built as byte/lane streams, expected reports are
// queued at issue time and a monitor checks reports, totals and window rates.
module tb_xgmii_rx_measure;

  localparam int CPS  = 100;
  localparam int MINL = 64;
  localparam int MAXL = 1518;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [63:0] xgmii_rxd = {8{8'h07}};
  logic [7:0]  xgmii_rxc = 8'hFF;
  logic        frame_valid, frame_err;
  logic [15:0] frame_len;
  logic [31:0] rx_frames, rx_errors, rx_pps, rx_throughput;
  logic [47:0] rx_bytes;

  always #5 sys_clk = ~sys_clk;

  xgmii_rx_measure #(.CLK_PER_SEC(CPS), .MIN_LEN(MINL), .MAX_LEN(MAXL)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .xgmii_rxd     (xgmii_rxd),
    .xgmii_rxc     (xgmii_rxc),
    .frame_valid   (frame_valid),
    .frame_len     (frame_len),
    .frame_err     (frame_err),
    .rx_frames     (rx_frames),
    .rx_bytes      (rx_bytes),
    .rx_errors     (rx_errors),
    .rx_pps        (rx_pps),
    .rx_throughput (rx_throughput)
  );

  typedef struct { int len; bit err; } exp_t;   // len < 0: length not checked
  exp_t     expq[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       win_f[0:1023];
  longint   win_b[0:1023];
  longint   m_frames, m_bytes, m_errors;
  bit [7:0] lq_d[$];
  bit       lq_c[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : mon
    bit   r;
    bit   pend;
    int   idx;
    exp_t e;
    pend = 0;
    m_frames = 0; m_bytes = 0; m_errors = 0;
    for (int i = 0; i < 1024; i++) begin win_f[i] = 0; win_b[i] = 0; end
    forever begin
      @(posedge sys_clk);
      r = sys_rst;
      @(negedge sys_clk);
      if (!r || !sys_rst) begin
        cyc = 0; pend = 0;
        m_frames = 0; m_bytes = 0; m_errors = 0;
        for (int i = 0; i < 1024; i++) begin win_f[i] = 0; win_b[i] = 0; end
      end else begin
        cyc++;
        if (pend) begin
          chk("rx_frames", rx_frames, m_frames);
          chk("rx_bytes", rx_bytes, m_bytes);
          chk("rx_errors", rx_errors, m_errors);
          pend = 0;
        end
        if ((cyc % CPS) == 0 && (cyc / CPS) < 1024) begin
          chk("rx_pps", rx_pps, win_f[cyc / CPS]);
          chk("rx_throughput", rx_throughput, win_b[cyc / CPS]);
        end
        if (frame_valid) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame_valid: got len %0d err %0d expected none", frame_len, frame_err);
          end else begin
            e = expq.pop_front();
            chk("frame_err", frame_err, e.err);
            if (e.len >= 0) chk("frame_len", frame_len, e.len);
            if (!e.err) begin
              m_frames++;
              m_bytes += e.len;
              idx = (cyc + CPS) / CPS;
              if (idx < 1024) begin win_f[idx]++; win_b[idx] += e.len; end
            end else begin
              m_errors++;
            end
            pend = 1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic drive(input bit [63:0] d, input bit [7:0] c);
    @(posedge sys_clk); #1;
    xgmii_rxd = d;
    xgmii_rxc = c;
  endtask

  task automatic idle_words(input int n);
    for (int i = 0; i < n; i++) drive({8{8'h07}}, 8'hFF);
  endtask

  task automatic put(input bit c, input bit [7:0] d);
    lq_c.push_back(c);
    lq_d.push_back(d);
  endtask

  task automatic pad_idle_to(input int lane);
    while ((lq_c.size() % 8) != lane) put(1'b1, 8'h07);
  endtask

  task automatic flush();
    while (lq_c.size() >= 8) begin
      bit [63:0] d;
      bit [7:0]  c;
      for (int k = 0; k < 8; k++) begin
        c[k]         = lq_c.pop_front();
        d[8*k +: 8]  = lq_d.pop_front();
      end
      drive(d, c);
    end
  endtask

  task automatic put_head(input int sl);
    pad_idle_to(sl);
    put(1'b1, 8'hFB);
    repeat (6) put(1'b0, 8'h55);
    put(1'b0, 8'hD5);
  endtask

  // L payload bytes (FCS included); fe_j >= 0 replaces that byte with an Error char.
  task automatic send_frame(input int L, input int sl, input int fe_j);
    exp_t e;
    e.err = (fe_j >= 0) || (L < MINL) || (L > MAXL);
    e.len = (fe_j >= 0) ? -1 : L;
    expq.push_back(e);
    put_head(sl);
    for (int j = 0; j < L; j++) begin
      if (j == fe_j) put(1'b1, 8'hFE);
      else           put(1'b0, 8'($urandom));
    end
    put(1'b1, 8'hFD);
    pad_idle_to(0);
    repeat (8) put(1'b1, 8'h07);
    flush();
  endtask

  // Word-aligned partial frame cut short by the next Start.
  task automatic send_abort(input int D);
    exp_t e;
    e.err = 1'b1;
    e.len = D;
    expq.push_back(e);
    put_head(0);
    for (int j = 0; j < D; j++) put(1'b0, 8'($urandom));
    flush();
  endtask

  task automatic wait_win_end();
    int n;
    n = 0;
    do begin
      @(negedge sys_clk); #1;
      n++;
    end while ((cyc % CPS) != 0 && n < 2 * CPS);
    if ((cyc % CPS) != 0) begin
      checks++; errors++;
      $display("FAIL win_wait: got cyc %0d expected multiple of %0d", cyc, CPS);
    end
  endtask

  initial begin : stim
    int L, sl, fe, r;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_rx_frames", rx_frames, 0);
    chk("rst_rx_bytes", rx_bytes, 0);
    chk("rst_rx_errors", rx_errors, 0);
    chk("rst_rx_pps", rx_pps, 0);
    chk("rst_rx_throughput", rx_throughput, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    idle_words(3);

    send_frame(64, 0, -1);
    idle_words(3);
    chk("dir64_frames", rx_frames, 1);
    chk("dir64_bytes", rx_bytes, 64);

    send_frame(1518, 4, -1);
    send_frame(1519, 0, -1);
    idle_words(3);
    chk("dirmax_frames", rx_frames, 2);
    chk("dirmax_errors", rx_errors, 1);
    chk("dirmax_bytes", rx_bytes, 1582);

    send_frame(100, 0, 19);
    idle_words(3);
    chk("dirfe_frames", rx_frames, 2);
    chk("dirfe_errors", rx_errors, 2);

    send_abort(24);
    send_frame(64, 0, -1);
    idle_words(3);
    chk("dirabort_errors", rx_errors, 3);
    chk("dirabort_frames", rx_frames, 3);
    chk("dirabort_bytes", rx_bytes, 1646);

    idle_words(4);
    wait_win_end();
    repeat (3) send_frame(64, 0, -1);
    wait_win_end();
    chk("win3_pps", rx_pps, 3);
    chk("win3_throughput", rx_throughput, 192);
    wait_win_end();
    chk("winidle_pps", rx_pps, 0);
    chk("winidle_throughput", rx_throughput, 0);

    for (int i = 0; i < 25; i++) begin
      r  = $urandom_range(0, 3);
      case (r)
        0:       L = $urandom_range(58, 70);
        1:       L = $urandom_range(1512, 1524);
        2:       L = $urandom_range(64, 300);
        default: L = $urandom_range(40, 80);
      endcase
      sl = $urandom_range(0, 1) * 4;
      fe = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      send_frame(L, sl, fe);
      idle_words($urandom_range(0, 2));
    end

    idle_words(3);
    put_head(0);
    for (int j = 0; j < 16; j++) put(1'b0, 8'($urandom));
    flush();
    @(posedge sys_clk); #1;
    sys_rst   = 1'b0;
    xgmii_rxd = {8{8'h07}};
    xgmii_rxc = 8'hFF;
    repeat (2) begin
      @(negedge sys_clk);
      chk("midrst_frame_valid", frame_valid, 0);
      chk("midrst_frame_len", frame_len, 0);
      chk("midrst_rx_frames", rx_frames, 0);
      chk("midrst_rx_bytes", rx_bytes, 0);
      chk("midrst_rx_errors", rx_errors, 0);
      chk("midrst_rx_pps", rx_pps, 0);
    end
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    idle_words(3);
    send_frame(64, 4, -1);
    idle_words(4);
    chk("postrst_frames", rx_frames, 1);
    chk("postrst_bytes", rx_bytes, 64);
    chk("postrst_errors", rx_errors, 0);

    idle_words(20);
    chk("exp_queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
